// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the Sobel datapath: tracks raster position, drives the
// line buffer, qualifies 3x3 windows and aligns output-valid to the pipeline.
module sobel_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pix_valid_i,
  output logic             lb_wr_en_o,
  output logic [COL_W-1:0] lb_addr_o,
  output logic             pad_o,
  output logic             window_valid_o,
  output logic             border_o,
  output logic             out_valid_o,
  output logic             out_zero_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             err_o
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int K_MAX = NPIX + IMG_W;
  localparam int K_W   = $clog2(K_MAX + 1);
  localparam int D_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [K_W-1:0]       k_q, k_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [COL_W-1:0]     ccol_q, ccol_d;
  logic [ROW_W-1:0]     crow_q, crow_d;
  logic [D_W-1:0]       drain_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [PIPE_LAT-1:0]  dlv_q;
  logic [PIPE_LAT-1:0]  dlz_q;
  logic                 step;
  logic                 win;

  always_comb begin
    step = ((state_q == S_FILL) || (state_q == S_RUN)) && pix_valid_i;
    step = step || (state_q == S_FLUSH);
    win  = ((state_q == S_RUN) && pix_valid_i) || (state_q == S_FLUSH);

    k_d   = k_q + K_W'(1);
    col_d = (col_q == COL_W'(IMG_W - 1)) ? '0 : col_q + COL_W'(1);

    // Centre raster position advances with every emitted window.
    ccol_d = ccol_q;
    crow_d = crow_q;
    if (ccol_q == COL_W'(IMG_W - 1)) begin
      ccol_d = '0;
      crow_d = (crow_q == ROW_W'(IMG_H - 1)) ? '0 : crow_q + ROW_W'(1);
    end else begin
      ccol_d = ccol_q + COL_W'(1);
    end
  end

  assign lb_wr_en_o     = step;
  assign lb_addr_o      = col_q;
  assign pad_o          = (state_q == S_FLUSH);
  assign window_valid_o = win;
  assign border_o       = win && ((crow_q == '0) || (crow_q == ROW_W'(IMG_H - 1)) ||
                                  (ccol_q == '0) || (ccol_q == COL_W'(IMG_W - 1)));
  assign out_valid_o    = dlv_q[PIPE_LAT-1];
  assign out_zero_o     = dlz_q[PIPE_LAT-1];
  assign busy_o         = busy_q;
  assign frame_done_o   = done_q;
  assign err_o          = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      col_q   <= '0;
      ccol_q  <= '0;
      crow_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= S_FILL;
            k_q     <= '0;
            col_q   <= '0;
            ccol_q  <= '0;
            crow_q  <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        S_FILL: begin
          if (pix_valid_i) begin
            k_q   <= k_d;
            col_q <= col_d;
            if (k_q == K_W'(IMG_W)) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (pix_valid_i) begin
            k_q    <= k_d;
            col_q  <= col_d;
            ccol_q <= ccol_d;
            crow_q <= crow_d;
            if (k_q == K_W'(NPIX - 1)) state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          col_q  <= col_d;
          ccol_q <= ccol_d;
          crow_q <= crow_d;
          if (pix_valid_i) err_q <= 1'b1;
          if (k_q == K_W'(K_MAX)) begin
            state_q <= S_DRAIN;
            drain_q <= D_W'(PIPE_LAT - 1);
          end else begin
            k_q <= k_d;
          end
        end
        S_DRAIN: begin
          if (pix_valid_i) err_q <= 1'b1;
          // Last window enters the delay line on the final flush cycle.
          if (drain_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - D_W'(1);
          end
        end
        S_DONE: begin
          if (pix_valid_i) err_q <= 1'b1;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dlv_q <= '0;
      dlz_q <= '0;
    end else begin
      dlv_q[0] <= win;
      dlz_q[0] <= border_o;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dlv_q[i] <= dlv_q[i-1];
        dlz_q[i] <= dlz_q[i-1];
      end
    end
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
- Frame sequencer for the Sobel edge-detection datapath.
- Accepts the raster pixel-valid stream feeding the gray/line-buffer/Sobel pipeline and tracks input row and column.
- Drives line-buffer write enable and address, marks when a 3x3 window is centred on a real pixel, flags border centres for zero output, and aligns output-valid to the Sobel compute latency.
- Self-generates the flush cycles after the last input, so the output pixel count always equals IMG_W*IMG_H.

Parameters:
- IMG_W, 640, pixels per row (>=3).
- IMG_H, 480, rows per frame (>=3).
- COL_W, 10, column counter width (2**COL_W >= IMG_W).
- ROW_W, 9, row counter width (2**ROW_W >= IMG_H).
- PIPE_LAT, 3, cycles from window_valid_o to the Sobel result at the datapath output (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse that arms a new frame; honoured only in IDLE.
- pix_valid_i  in  1  input pixel present this cycle.
- lb_wr_en_o  out  1  line-buffer shift/write enable.
- lb_addr_o  out  COL_W  line-buffer column address.
- pad_o  out  1  flush cycle; datapath muxes a zero pixel into the window.
- window_valid_o  out  1  3x3 window centred on a frame pixel this cycle.
- border_o  out  1  qualifies window_valid_o; centre lies on the frame edge.
- out_valid_o  out  1  datapath output pixel valid.
- out_zero_o  out  1  force datapath output to 0; aligned with out_valid_o.
- busy_o  out  1  high from start accepted until frame_done_o.
- frame_done_o  out  1  one-cycle pulse after the last out_valid_o.
- err_o  out  1  sticky flag: pix_valid_i seen outside IDLE/FILL/RUN; cleared by accepted start_i.

Behaviour:
Reset (rst=0, asynchronous, any state, including mid-frame):
- State goes to IDLE.
- All counters and the PIPE_LAT delay line clear.
- Every output is 0.

Step counter:
- k counts 0..W*H+W. It increments on each accepted pixel (k < W*H) or each flush cycle (k >= W*H).
- in_col/in_row are k mod W / k div W while k < W*H. Column wraps W-1 -> 0 and increments the row.
- Centre index is k-(W+1). Centre col/row use wrap counters that start at (0,0) when k = W+1.

States:
- IDLE: busy_o=0. start_i -> FILL, clear k, clear err_o. pix_valid_i in IDLE is ignored and does not set err_o.
- FILL (k = 0..W): each pix_valid_i asserts lb_wr_en_o in that cycle with lb_addr_o=in_col; no window. On the pixel where k = W -> RUN.
- RUN (k = W+1..W*H-1): each pix_valid_i asserts lb_wr_en_o and window_valid_o in the same cycle. On the pixel k = W*H-1 -> FLUSH.
- FLUSH: exactly W+1 consecutive cycles with no input handshake.
  - Each cycle: lb_wr_en_o=1, pad_o=1, window_valid_o=1.
  - lb_addr_o continues the column wrap.
  - After the cycle with k = W*H+W -> DRAIN.
- DRAIN: PIPE_LAT cycles for the delay line to empty, then -> DONE.
- DONE: frame_done_o=1 for one cycle, busy_o drops in the same cycle, -> IDLE.

Output rules:
- border_o = centre row in {0, H-1} or centre col in {0, W-1}; combinational with window_valid_o.
- Gaps in pix_valid_i stall FILL/RUN. Outputs stay 0 during stall cycles and no counter moves.
- out_valid_o = window_valid_o delayed exactly PIPE_LAT cycles. out_zero_o = border_o delayed identically.
- Per frame: exactly W*H window_valid_o and W*H out_valid_o, in raster order.
- pix_valid_i during FLUSH/DRAIN/DONE is ignored and sets err_o.
- start_i outside IDLE is ignored; start_i in the DONE cycle is ignored.
- Widths: k needs ceil(log2(W*H+W+1)) bits, sized internally; no arithmetic overflow is permitted.

Test Plan:
Common setup: IMG_W=4, IMG_H=3, PIPE_LAT=3.
1. Reset release, start_i, then 12 back-to-back pix_valid_i -> lb_wr_en_o on all 12. First window_valid_o on the 6th pixel (k=5). pad_o high for 5 cycles after the last pixel. Total window_valid_o = 12.
2. Same frame, border check -> border_o low only for centres (1,1) and (1,2), i.e. window_valid_o #6 and #7. out_zero_o shows the same pattern shifted 3 cycles.
3. Latency -> each out_valid_o is exactly 3 cycles after its window_valid_o. frame_done_o is 1 cycle after the 12th out_valid_o. busy_o falls in that cycle.
4. Stalled input: pix_valid_i pattern 1,0,0,1 repeated -> the same 12 windows in the same order. No outputs during stall cycles. Identical border sequence.
5. rst asserted mid-RUN (after pixel 8) -> all outputs 0 immediately. Next start_i runs a clean 12-pixel frame with correct counts.
6. pix_valid_i during FLUSH -> err_o=1 and held. start_i during FLUSH ignored. Next start_i in IDLE clears err_o.
